// File: rtl/clk_rst_pkg.sv
// ----------------------------------------------------------------------------
// clk_rst_pkg
// Shared definitions for the clock-enable / reset sequencer:
//   - state_t and the four FSM state encodings (WAIT_LOCK/HOLD/RUN/STRETCH)
//   - divider terminal counts (11 for /12, 15 for /16, 31 for /32)
//   - default LOCK_HOLD and RST_EXT values
//   - next_cnt12(): modulo-12 increment helper for the main-CPU divider
// ----------------------------------------------------------------------------
package clk_rst_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_LOCK = 2'd0;
    localparam state_t ST_HOLD      = 2'd1;
    localparam state_t ST_RUN       = 2'd2;
    localparam state_t ST_STRETCH   = 2'd3;

    localparam logic [3:0] CNT12_LAST    = 4'd11;
    localparam logic [3:0] CNT32_LO_LAST = 4'd15;
    localparam logic [4:0] CNT32_LAST    = 5'd31;

    localparam int unsigned LOCK_HOLD_DEF = 32'd1024;
    localparam int unsigned RST_EXT_DEF   = 32'd16;

    // Modulo-12 increment: wraps 11 -> 0 so every phase is visited once.
    function automatic logic [3:0] next_cnt12(input logic [3:0] cnt);
        logic [3:0] nxt;
        if (cnt == CNT12_LAST) begin
            nxt = 4'd0;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk    in  destination clock
//   rst_n  in  synchronous active-low reset (both flops cleared to 0)
//   d      in  asynchronous input
//   q      out synchronized output (two clk cycles of latency)
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; first stage may go metastable, second resolves it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/clk_rst_seq.sv
// ----------------------------------------------------------------------------
// clk_rst_seq
// Core reset sequencer and clock-enable generator. Waits for a stable PLL
// lock (LOCK_HOLD cycles), releases core_reset, then produces the CPU/PSG
// clock enables. soft_rst re-asserts core_reset, stretched by RST_EXT cycles
// after the request drops. Losing lock always returns to WAIT_LOCK.
// Parameters:
//   LOCK_HOLD  stable-lock cycles before release (2..65535)
//   RST_EXT    core_reset stretch after soft_rst falls (1..255)
// Ports:
//   clk_sys     in  48 MHz system clock (only clock in the block)
//   rst_n       in  synchronous active-low block reset
//   pll_locked  in  PLL lock flag, asynchronous
//   soft_rst    in  level-sensitive core reset request
//   pause       in  freezes clock enables (only with CLK_RST_SEQ_PAUSE_EN)
//   core_reset  out active-high downstream reset (registered)
//   ce_4m       out one-cycle enable every 12 cycles
//   ce_3m       out one-cycle enable every 16 cycles
//   ce_1m5      out one-cycle enable every 32 cycles
//   state_o     out current FSM state
// Build option: define CLK_RST_SEQ_PAUSE_EN to make pause functional;
// otherwise the port exists but is ignored.
// ----------------------------------------------------------------------------
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int unsigned LOCK_HOLD = LOCK_HOLD_DEF,
    parameter int unsigned RST_EXT   = RST_EXT_DEF
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_rst,
    input  logic       pause,
    output logic       core_reset,
    output logic       ce_4m,
    output logic       ce_3m,
    output logic       ce_1m5,
    output logic [1:0] state_o
);

    localparam logic [15:0] HOLD_LAST = 16'(LOCK_HOLD - 32'd1);
    localparam logic [7:0]  STR_LOAD  = 8'(RST_EXT - 32'd1);

    logic        lock_s;
    logic        pause_s;
    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] hold_cnt_r;
    logic [15:0] hold_nxt_s;
    logic [7:0]  str_cnt_r;
    logic [7:0]  str_nxt_s;
    logic [3:0]  cnt12_r;
    logic [4:0]  cnt32_r;
    logic        run_s;
    logic        adv_s;
    logic        core_reset_r;
    logic        ce_4m_r;
    logic        ce_3m_r;
    logic        ce_1m5_r;

    sync_2ff u_lock_sync (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

`ifdef CLK_RST_SEQ_PAUSE_EN
    assign pause_s = pause;
`else
    logic pause_unused_s;
    assign pause_unused_s = pause;
    assign pause_s        = 1'b0;
`endif

    // Next-state and counter-update logic; loss of lock overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_cnt_r;
        str_nxt_s   = str_cnt_r;
        if (!lock_s) begin
            state_nxt_s = ST_WAIT_LOCK;
            hold_nxt_s  = 16'd0;
            str_nxt_s   = 8'd0;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    state_nxt_s = ST_HOLD;
                    hold_nxt_s  = 16'd0;
                end
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_nxt_s = ST_RUN;
                        hold_nxt_s  = 16'd0;
                    end else begin
                        hold_nxt_s = hold_cnt_r + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (soft_rst) begin
                        state_nxt_s = ST_STRETCH;
                        str_nxt_s   = STR_LOAD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_STRETCH: begin
                    // Request still high: keep reloading so the stretch
                    // is measured from the falling edge of soft_rst.
                    if (soft_rst) begin
                        str_nxt_s = STR_LOAD;
                    end else if (str_cnt_r == 8'd0) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        str_nxt_s = str_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_WAIT_LOCK;
                    hold_nxt_s  = 16'd0;
                    str_nxt_s   = 8'd0;
                end
            endcase
        end
    end

    // Dividers only move while RUN continues; the cycle leaving RUN clears
    // them so a later RUN entry always starts from phase 0.
    assign run_s = (state_r == ST_RUN) && (state_nxt_s == ST_RUN);
    assign adv_s = run_s && !pause_s;

    // FSM state, sequencing counters and registered core_reset.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_r      <= ST_WAIT_LOCK;
            hold_cnt_r   <= 16'd0;
            str_cnt_r    <= 8'd0;
            core_reset_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            hold_cnt_r   <= hold_nxt_s;
            str_cnt_r    <= str_nxt_s;
            core_reset_r <= (state_nxt_s != ST_RUN);
        end
    end

    // Divider counters and registered clock enables.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            cnt12_r  <= 4'd0;
            cnt32_r  <= 5'd0;
            ce_4m_r  <= 1'b0;
            ce_3m_r  <= 1'b0;
            ce_1m5_r <= 1'b0;
        end else begin
            if (state_nxt_s != ST_RUN) begin
                cnt12_r <= 4'd0;
                cnt32_r <= 5'd0;
            end else if (adv_s) begin
                cnt12_r <= next_cnt12(cnt12_r);
                cnt32_r <= cnt32_r + 5'd1;
            end else begin
                cnt12_r <= cnt12_r;
                cnt32_r <= cnt32_r;
            end
            ce_4m_r  <= adv_s && (cnt12_r == CNT12_LAST);
            ce_3m_r  <= adv_s && (cnt32_r[3:0] == CNT32_LO_LAST);
            ce_1m5_r <= adv_s && (cnt32_r == CNT32_LAST);
        end
    end

    assign core_reset = core_reset_r;
    assign ce_4m      = ce_4m_r;
    assign ce_3m      = ce_3m_r;
    assign ce_1m5     = ce_1m5_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_clk_rst_seq.sv
// ----------------------------------------------------------------------------
// tb_clk_rst_seq
// Directed bench for clk_rst_seq with LOCK_HOLD=8, RST_EXT=16. Inputs change
// 1 ns after a rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_clk_rst_seq;

    logic       clk_sys;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_rst;
    logic       pause;
    logic       core_reset;
    logic       ce_4m;
    logic       ce_3m;
    logic       ce_1m5;
    logic [1:0] state_o;

    int n_vec;
    int n_err;

    clk_rst_seq #(
        .LOCK_HOLD (8),
        .RST_EXT   (16)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .pause      (pause),
        .core_reset (core_reset),
        .ce_4m      (ce_4m),
        .ce_3m      (ce_3m),
        .ce_1m5     (ce_1m5),
        .state_o    (state_o)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       rst_n;
        logic       pll;
        logic [1:0] exp_state;
        logic       exp_cr;
    } vec_t;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    vec_t       tbl [15];
    logic [1:0] exp_d [12];

    initial begin
        int last4, last3, last1, n4, n3, n1, k;
        logic exp4, exp3, exp1;
        n_vec = 0;
        n_err = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        soft_rst   = 1'b0;
        pause      = 1'b0;

        // Startup: 4 reset edges, then sync (2), HOLD (8), RUN.
        for (int i = 0; i < 15; i++) begin
            tbl[i].pll = 1'b1;
            tbl[i].rst_n = (i >= 4) ? 1'b1 : 1'b0;
            if (i < 6) begin
                tbl[i].exp_state = 2'd0;
            end else if (i < 14) begin
                tbl[i].exp_state = 2'd1;
            end else begin
                tbl[i].exp_state = 2'd2;
            end
            tbl[i].exp_cr = (i < 14) ? 1'b1 : 1'b0;
        end
        for (int i = 0; i < 15; i++) begin
            rst_n      = tbl[i].rst_n;
            pll_locked = tbl[i].pll;
            tick();
            chk("start_state", i, 32'(state_o), 32'(tbl[i].exp_state));
            chk("start_core_reset", i, 32'(core_reset), 32'(tbl[i].exp_cr));
            chk("start_ce", i, 32'({ce_4m, ce_3m, ce_1m5}), 32'd0);
        end

        // 384 RUN cycles: counts and spacing of each enable.
        last4 = 0; last3 = 0; last1 = 0; n4 = 0; n3 = 0; n1 = 0;
        for (int c = 1; c <= 384; c++) begin
            tick();
            if (ce_4m) begin
                n4++;
                chk("ce4_gap", c, 32'(c - last4), 32'd12);
                last4 = c;
            end
            if (ce_3m) begin
                n3++;
                chk("ce3_gap", c, 32'(c - last3), 32'd16);
                last3 = c;
            end
            if (ce_1m5) begin
                n1++;
                chk("ce1m5_gap", c, 32'(c - last1), 32'd32);
                last1 = c;
            end
        end
        chk("ce4_count", 0, 32'(n4), 32'd32);
        chk("ce3_count", 0, 32'(n3), 32'd24);
        chk("ce1m5_count", 0, 32'(n1), 32'd12);
        chk("run_core_reset", 0, 32'(core_reset), 32'd0);

        // soft_rst high for 5 edges: STRETCH until edge 20, RUN at 21,
        // dividers restart from 0.
        soft_rst = 1'b1;
        for (int j = 1; j <= 38; j++) begin
            tick();
            if (j == 5) soft_rst = 1'b0;
            chk("soft_core_reset", j, 32'(core_reset), (j <= 20) ? 32'd1 : 32'd0);
            chk("soft_state", j, 32'(state_o), (j <= 20) ? 32'd3 : 32'd2);
            chk("soft_ce4", j, 32'(ce_4m), (j == 33) ? 32'd1 : 32'd0);
            chk("soft_ce3", j, 32'(ce_3m), (j == 37) ? 32'd1 : 32'd0);
            chk("soft_ce1m5", j, 32'(ce_1m5), 32'd0);
        end

        // cnt12 is now 5, cnt32 is 17: pause for 7 edges.
        pause = 1'b1;
        for (int m = 1; m <= 24; m++) begin
            tick();
            if (m == 7) pause = 1'b0;
`ifdef CLK_RST_SEQ_PAUSE_EN
            exp4 = (m == 14);
            exp3 = (m == 22);
`else
            exp4 = (m == 7) || (m == 19);
            exp3 = (m == 15);
`endif
            exp1 = exp3;
            chk("pause_ce4", m, 32'(ce_4m), 32'(exp4));
            chk("pause_ce3", m, 32'(ce_3m), 32'(exp3));
            chk("pause_ce1m5", m, 32'(ce_1m5), 32'(exp1));
        end

        // Lock loss in RUN: WAIT_LOCK on the third edge.
        pll_locked = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            tick();
            chk("lockloss_state", p, 32'(state_o), (p == 3) ? 32'd0 : 32'd2);
            chk("lockloss_core_reset", p, 32'(core_reset), (p == 3) ? 32'd1 : 32'd0);
        end
        chk("lockloss_ce", 0, 32'({ce_4m, ce_3m, ce_1m5}), 32'd0);

        // Relock, reach HOLD count 5, then a one-cycle lock glitch.
        pll_locked = 1'b1;
        k = 0;
        while (state_o != 2'd1 && k < 10) begin
            tick();
            k++;
        end
        chk("relock_hold_entry", 0, 32'(k), 32'd3);
        for (int h = 0; h < 5; h++) tick();
        pll_locked = 1'b0;
        exp_d = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                  2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        for (int g = 0; g < 12; g++) begin
            tick();
            if (g == 0) pll_locked = 1'b1;
            chk("glitch_state", g, 32'(state_o), 32'(exp_d[g]));
            chk("glitch_core_reset", g, 32'(core_reset), (g < 11) ? 32'd1 : 32'd0);
        end

        // Lock loss while soft_rst is held in RUN.
        for (int r = 0; r < 3; r++) tick();
        soft_rst   = 1'b1;
        pll_locked = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("drop_soft_state", e, 32'(state_o), (e <= 2) ? 32'd3 : 32'd0);
            chk("drop_soft_core_reset", e, 32'(core_reset), 32'd1);
            chk("drop_soft_ce", e, 32'({ce_4m, ce_3m, ce_1m5}), 32'd0);
        end

        // Block reset mid-HOLD clears the synchronizer and abandons the count.
        soft_rst   = 1'b0;
        pll_locked = 1'b1;
        for (int r = 0; r < 4; r++) tick();
        chk("pre_reset_state", 0, 32'(state_o), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("midhold_reset_state", 0, 32'(state_o), 32'd0);
        chk("midhold_reset_core_reset", 0, 32'(core_reset), 32'd1);
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("post_reset_state", e, 32'(state_o), (e == 3) ? 32'd1 : 32'd0);
            chk("post_reset_core_reset", e, 32'(core_reset), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
